// File: rtl/odd_chk_pkg.sv
// Shared types and constants for the odd-sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package odd_chk_pkg;

  // Checker states; IDLE is where the block waits for an odd sample to lock onto.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Default width of the monitored count bus.
  localparam int DEFAULT_WIDTH = 8;

  // Error total is a fixed 8-bit saturating counter.
  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage : odd_chk_pkg

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up-counter: increments on inc, holds at MAX, synchronous clr.
// Latency: value updates on the rising edge after inc/clr.
// Backpressure: none; inc is ignored once MAX is reached.
module sat_counter
  import odd_chk_pkg::*;
#(
  parameter int           W   = ERR_CNT_W,
  parameter logic [W-1:0] MAX = ERR_CNT_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // Count register: clr has priority over inc, saturates at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (clr) begin
      value_q <= '0;
    end else if (inc && (value_q != MAX)) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule : sat_counter

// File: rtl/odd_seq_checker.sv
// Checks that a monitored counter steps through odd values (+2, wrapping mod 2^WIDTH).
// Latency: every output is registered and reflects the sample taken on the previous edge.
// Backpressure: none; en qualifies samples. ODD_CHK_STICKY_EN makes err a sticky level.
module odd_seq_checker
  import odd_chk_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LOCK_CNT = 4,
  parameter int MAX_ERR  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap,
  output logic                 fault
);

  // Run counter only needs to reach LOCK_CNT; it saturates there.
  localparam int               RUN_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 wrap_q, wrap_d;
  logic                 fault_q, fault_d;

  logic                 err_ev;
  logic                 err_limit_hit;
  logic [ERR_CNT_W-1:0] err_count_w;

  // The increment about to be applied would bring the total to MAX_ERR.
  assign err_limit_hit = (int'(err_count_w) + 1) >= MAX_ERR;

  // Error total; clear resets it, errors bump it, it never wraps.
  sat_counter #(
    .W   (ERR_CNT_W),
    .MAX (ERR_CNT_MAX)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (err_ev),
    .value (err_count_w)
  );

  // Next-state and registered-output logic; clear dominates sampling.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    run_d    = run_q;
    locked_d = locked_q;
    wrap_d   = 1'b0;
    fault_d  = fault_q;
    err_d    = err_q;
    err_ev   = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      exp_d    = '0;
      run_d    = '0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
      err_d    = 1'b0;
    end else begin
      if (en) begin
        case (state_q)
          ST_IDLE: begin
            if (count[0]) begin
              // First odd sample seeds the expected next value.
              exp_d   = count + WIDTH'(2);
              run_d   = RUN_W'(1);
              state_d = ST_TRACK;
            end else begin
              err_ev = 1'b1;
            end
          end
          ST_TRACK: begin
            if (count == exp_q) begin
              exp_d = count + WIDTH'(2);
              if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
              end
              // exp==1 can only follow a 2^WIDTH-1 sample, so this is a wrap.
              wrap_d = (count == WIDTH'(1));
            end else begin
              err_ev = 1'b1;
              run_d  = '0;
              if (count[0]) begin
                // Odd but out of sequence: follow the new phase.
                exp_d = count + WIDTH'(2);
              end else begin
                // Even value cannot belong to the sequence: reacquire.
                exp_d   = '0;
                state_d = ST_IDLE;
              end
            end
          end
          ST_FAULT: begin
            // Samples are ignored until clear or reset.
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase

        if (err_ev && err_limit_hit) begin
          state_d = ST_FAULT;
          run_d   = '0;
        end

        locked_d = (state_d == ST_TRACK) && (run_d == RUN_MAX);
        fault_d  = (state_d == ST_FAULT);
      end

`ifdef ODD_CHK_STICKY_EN
      err_d = err_q | err_ev;
`else
      err_d = err_ev;
`endif
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      exp_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      fault_q  <= fault_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_w;
  assign wrap      = wrap_q;
  assign fault     = fault_q;

endmodule : odd_seq_checker

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: table of samples plus multi-cycle corner sequences.
// Latency: outputs are checked 1 time unit after the edge that took the sample.
// Backpressure: n/a. Expected err follows ODD_CHK_STICKY_EN when defined.
module tb_odd_seq_checker;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] count;
  logic       clear;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic       wrap;
  logic       fault;

  int checks;
  int failures;
  logic err_acc;

  typedef struct {
    logic       en;
    logic [7:0] cnt;
    logic       clr;
    logic       x_locked;
    logic       x_err;
    logic       x_wrap;
    logic       x_fault;
    logic [7:0] x_ec;
  } vec_t;

  vec_t tbl [18];

  odd_seq_checker #(
    .WIDTH    (8),
    .LOCK_CNT (4),
    .MAX_ERR  (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .count     (count),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .wrap      (wrap),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic xl, input logic xe,
                         input logic xw, input logic xf, input logic [7:0] xec);
    chk({nm, ".locked"},    {7'b0, locked}, {7'b0, xl});
    chk({nm, ".err"},       {7'b0, err},    {7'b0, xe});
    chk({nm, ".wrap"},      {7'b0, wrap},   {7'b0, xw});
    chk({nm, ".fault"},     {7'b0, fault},  {7'b0, xf});
    chk({nm, ".err_count"}, err_count,      xec);
  endtask

  // Drive one sample, let one edge take it, then compare the registered response.
  // x_err is the per-sample pulse; in sticky mode it is accumulated until clear.
  task automatic apply(input string nm, input logic e, input logic [7:0] c, input logic cl,
                       input logic xl, input logic xe, input logic xw, input logic xf,
                       input logic [7:0] xec);
    logic exp_err;
    en    = e;
    count = c;
    clear = cl;
    @(posedge clk);
    #1;
    if (cl) err_acc = 1'b0;
    else    err_acc = err_acc | xe;
`ifdef ODD_CHK_STICKY_EN
    exp_err = err_acc;
`else
    exp_err = xe;
`endif
    chk_all(nm, xl, exp_err, xw, xf, xec);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    err_acc  = 1'b0;
    reset    = 1'b1;
    en       = 1'b0;
    count    = 8'd0;
    clear    = 1'b0;

    //           en    cnt    clr   lock  err   wrap  fault ec
    tbl[0]  = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 8'd7,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 8'd11,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 8'd14,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 8'd17,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 8'd19,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 8'd21,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 8'd25,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{1'b1, 8'd27,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{1'b1, 8'd29,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{1'b1, 8'd31,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[16] = '{1'b1, 8'd33,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[17] = '{1'b1, 8'd35,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Reset for two cycles; outputs must already be zero.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    // Lock, hold on en=0, even-mismatch to IDLE, reacquire, odd resync, clear.
    for (int i = 0; i < 18; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].en, tbl[i].cnt, tbl[i].clr,
            tbl[i].x_locked, tbl[i].x_err, tbl[i].x_wrap, tbl[i].x_fault, tbl[i].x_ec);
    end

    // en low in IDLE: nothing changes, no pulses.
    apply("idle_hold", 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Full odd sweep 1..255 then 1: one wrap pulse, only after the final 1.
    for (int v = 1; v <= 255; v += 2) begin
      apply($sformatf("sweep%0d", v), 1'b1, v[7:0], 1'b0,
            (v >= 7), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    apply("wrap_1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    apply("post_wrap_3", 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("sweep_clear", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Fifteen errors from IDLE push the block into FAULT on the last one.
    for (int i = 1; i <= 15; i++) begin
      apply($sformatf("err%0d", i), 1'b1, 8'(2 * i), 1'b0,
            1'b0, 1'b1, 1'b0, (i == 15), 8'(i));
    end
    apply("fault_ign_odd",  1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd15);
    apply("fault_ign_even", 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd15);
    // Clear beats en: the sample 1 must not be taken, so 5 is a fresh acquisition.
    apply("fault_clear", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("after_clr_5", 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("after_clr_7", 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("pre_rst_clr", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // One error, then sweep to 101 and pull reset between edges.
    apply("pre_rst_err", 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int v = 1; v <= 101; v += 2) begin
      apply($sformatf("rsweep%0d", v), 1'b1, v[7:0], 1'b0,
            (v >= 7), 1'b0, 1'b0, 1'b0, 8'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    err_acc = 1'b0;
    chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    // Tracking was abandoned: 103 is a fresh acquisition, 105 a match.
    apply("resume_103", 1'b1, 8'd103, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("resume_105", 1'b1, 8'd105, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    apply("resume_bad", 1'b1, 8'd111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    apply("resume_idle", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_odd_seq_checker

// File: doc/odd_seq_checker.md
ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the monitored count bus.
REQ-002 Parameter LOCK_CNT, default 4, consecutive correct samples required to assert locked.
REQ-003 Parameter MAX_ERR, default 15, error count at which the block enters FAULT.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  sample enable; count is examined only in cycles with en=1.
REQ-007 Port count  input  WIDTH  value driven by the odd counter under observation.
REQ-008 Port clear  input  1  synchronous clear of errors/FAULT and return to IDLE.
REQ-009 Port locked  output  1  high while tracking after LOCK_CNT consecutive matches.
REQ-010 Port err  output  1  one-cycle pulse per detected error.
REQ-011 Port err_count  output  8  saturating error total.
REQ-012 Port wrap  output  1  one-cycle pulse on a correct wrap from 2^WIDTH-1 to 1.
REQ-013 Port fault  output  1  high while in FAULT.

Function
REQ-014 States SHALL be IDLE, TRACK, FAULT; IDLE is the reset state.
REQ-015 All outputs SHALL be registered; response to a sample appears the cycle after the sampling edge.
REQ-016 IDLE, en=1, count[0]=1: store exp = count+2 mod 2^WIDTH, go TRACK, run counter = 1, no err.
REQ-017 IDLE, en=1, count[0]=0: err pulse, err_count increment, stay IDLE.
REQ-018 TRACK, en=1, count==exp: exp = count+2 mod 2^WIDTH, run counter increments, saturating at LOCK_CNT.
REQ-019 locked SHALL assert the cycle after run counter reaches LOCK_CNT and stay high until a mismatch, clear, or reset.
REQ-020 TRACK, en=1, count!=exp: err pulse, err_count increment, locked deasserts, run counter = 0.
REQ-021 On a TRACK mismatch, an odd count SHALL resynchronise (exp = count+2); an even count SHALL return to IDLE.
REQ-022 wrap SHALL pulse when count==1 matches exp in TRACK (prior sample 2^WIDTH-1).
REQ-023 en=0 SHALL hold all state; err and wrap SHALL be low.
REQ-024 err_count SHALL saturate at 255 and never wrap.
REQ-025 When err_count reaches MAX_ERR, the state SHALL become FAULT; fault stays high and samples are ignored.
REQ-026 clear=1 SHALL have priority over en: err_count=0, run=0, locked=0, fault=0, state IDLE next cycle.
REQ-027 Reset asserted mid-operation SHALL abandon tracking immediately, with no err pulse.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, exp=0, run=0, locked=0, err=0, err_count=0, wrap=0, fault=0.
REQ-029 Sampling SHALL resume at the first rising edge with reset low.

Configuration
REQ-030 With ODD_CHK_STICKY_EN defined, err SHALL be a sticky level, cleared only by clear or reset.
REQ-031 Without ODD_CHK_STICKY_EN, err SHALL be a one-cycle pulse per error.

Structure
REQ-032 Package odd_chk_pkg SHALL hold the state enum, default WIDTH, and the err_count width/saturation constant.
REQ-033 Saturating error counting SHALL be a sub-module sat_counter (inc, clr, value, saturate at max).

Verification
REQ-034 Reset for 2 cycles, then count 1,3,5,7,9 with en=1 -> locked=1 after the 4th match, err never asserted.
REQ-035 Sweep 1..255 then 1 -> exactly one wrap pulse, on the cycle after count=1 is sampled; err_count=0.
REQ-036 Locked at 11, then inject 14 -> err pulse, locked=0, IDLE; next 15 -> TRACK; locked after 4 matches.
REQ-037 Locked at 21, then inject 25 -> err pulse, resync; 27 accepted with no error.
REQ-038 Inject 15 errors -> fault=1 and further samples ignored; clear -> fault=0, err_count=0, IDLE.
REQ-039 Assert reset mid-sweep at count=101 -> all outputs zero asynchronously; macro on/off runs confirm err pulse vs sticky.
